// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port controller.
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef logic [WB_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t              rd;
    logic [WB_DATA_W-1:0]  data;
  } md_res_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/wb_md_fifo.sv
// Small synchronous FIFO holding multiply/divide results.
module wb_md_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push_i);
      rp_q  <= rp_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i)
                     - (AW+1)'(pop_i);
    end
  end

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rp_q];
endmodule

// File: rtl/wb_port_ctrl.sv
// Register-file write port: pipeline vs mul/div merge plus scoreboard.
// Optional WB_BYPASS_EN adds same-cycle forwarding of the pending write.
module wb_port_ctrl
  import wb_pkg::*;
#(
  parameter int DATA_W       = WB_DATA_W,
  parameter int ADDR_W       = WB_ADDR_W,
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pipe_valid,
  input  logic [ADDR_W-1:0]    pipe_rd,
  input  logic [DATA_W-1:0]    pipe_data,
  input  logic                 md_issue,
  input  logic [ADDR_W-1:0]    md_issue_rd,
  input  logic                 md_valid,
  input  logic [ADDR_W-1:0]    md_rd,
  input  logic [DATA_W-1:0]    md_data,
  output logic                 md_ready,
  output logic                 stall_req,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] busy_vec
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]    rs_a,
  input  logic [ADDR_W-1:0]    rs_b,
  output logic                 fwd_a_hit,
  output logic                 fwd_b_hit,
  output logic [DATA_W-1:0]    fwd_a_data,
  output logic [DATA_W-1:0]    fwd_b_data
`endif
);
  localparam int NREG  = 2**ADDR_W;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam int RES_W = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } res_t;

  logic [ADDR_W-1:0] zero_rd;
  assign zero_rd = ADDR_W'(REG_ZERO);

  res_t              head, din;
  logic [RES_W-1:0]  head_raw;
  logic              q_full, q_empty;
  logic              push, pop;

  assign din  = '{rd: md_rd, data: md_data};
  assign head = head_raw;

  wb_md_fifo #(
    .WIDTH (RES_W),
    .DEPTH (MD_DEPTH)
  ) u_md_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head_raw)
  );

  // Ready depends on stored state only, so a full queue never pops and
  // accepts in the same cycle.
  assign md_ready = !q_full;
  assign push     = md_valid && !q_full;
  assign pop      = !pipe_valid && !q_empty;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, sel_rd;
  logic [DATA_W-1:0] wr_data_q, sel_data;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              stall_q, stall_d;
  logic              sel_v;

  always_comb begin
    sel_v    = 1'b0;
    sel_rd   = head.rd;
    sel_data = head.data;
    unique case (1'b1)
      pipe_valid: begin
        sel_v    = 1'b1;
        sel_rd   = pipe_rd;
        sel_data = pipe_data;
      end
      pop:     sel_v = 1'b1;
      default: sel_v = 1'b0;
    endcase
    wr_en_d = sel_v && (sel_rd != zero_rd);
  end

  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head.rd] = 1'b0;
    if (md_issue && md_issue_rd != zero_rd)
      busy_d[md_issue_rd] = 1'b1;
  end

  always_comb begin
    age_d = age_q;
    if (pop || q_empty)
      age_d = '0;
    else if (age_q != AGE_W'(STARVE_LIMIT))
      age_d = age_q + AGE_W'(1);
    stall_d = stall_q;
    if (pop)
      stall_d = 1'b0;
    else if (age_q == AGE_W'(STARVE_LIMIT))
      stall_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      age_q     <= '0;
      stall_q   <= 1'b0;
    end else begin
      wr_en_q <= wr_en_d;
      if (wr_en_d) begin
        wr_addr_q <= sel_rd;
        wr_data_q <= sel_data;
      end
      busy_q  <= busy_d;
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy_vec  = busy_q;
  assign stall_req = stall_q;

`ifdef WB_BYPASS_EN
  assign fwd_a_hit  = wr_en_q && wr_addr_q == rs_a
                      && rs_a != zero_rd;
  assign fwd_b_hit  = wr_en_q && wr_addr_q == rs_b
                      && rs_b != zero_rd;
  assign fwd_a_data = wr_data_q;
  assign fwd_b_data = wr_data_q;
`endif
endmodule

// File: tb/tb_wb_port_ctrl.sv
// Randomised and directed bench for wb_port_ctrl against a queue model.
module tb_wb_port_ctrl;
  import wb_pkg::*;

  localparam int MD_DEPTH = 2;
  localparam int LIMIT    = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        md_issue = 1'b0;
  logic [4:0]  md_issue_rd = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready, stall_req, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy_vec;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs_a = '0, rs_b = '0;
  logic        fwd_a_hit, fwd_b_hit;
  logic [31:0] fwd_a_data, fwd_b_data;
`endif

  wb_port_ctrl #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .MD_DEPTH     (MD_DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pipe_valid  (pipe_valid),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .md_issue    (md_issue),
    .md_issue_rd (md_issue_rd),
    .md_valid    (md_valid),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .md_ready    (md_ready),
    .stall_req   (stall_req),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy_vec    (busy_vec)
`ifdef WB_BYPASS_EN
    ,
    .rs_a        (rs_a),
    .rs_b        (rs_b),
    .fwd_a_hit   (fwd_a_hit),
    .fwd_b_hit   (fwd_b_hit),
    .fwd_a_data  (fwd_a_data),
    .fwd_b_data  (fwd_b_data)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  md_res_t     q[$];
  logic [31:0] m_busy = '0;
  int          m_wait = 0;
  bit          m_stall = 1'b0;
  bit          m_en = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock: predict from the rules, advance, compare.
  task automatic step();
    bit      ready, popped, was_empty;
    md_res_t h;
    ready     = q.size() < MD_DEPTH;
    was_empty = q.size() == 0;
    chk("md_ready", md_ready, ready);
    popped = !pipe_valid && !was_empty;
    m_en = 1'b0;
    if (pipe_valid) begin
      if (pipe_rd != 0) begin
        m_en = 1'b1; m_addr = pipe_rd; m_data = pipe_data;
      end
    end else if (popped) begin
      h = q.pop_front();
      m_busy[h.rd] = 1'b0;
      if (h.rd != 0) begin
        m_en = 1'b1; m_addr = h.rd; m_data = h.data;
      end
    end
    if (md_issue && md_issue_rd != 0) m_busy[md_issue_rd] = 1'b1;
    if (md_valid && ready) q.push_back('{md_rd, md_data});
    if (popped) begin
      m_wait = 0; m_stall = 1'b0;
    end else if (was_empty) begin
      m_wait = 0;
    end else begin
      if (m_wait == LIMIT) m_stall = 1'b1;
      if (m_wait < LIMIT) m_wait++;
    end
    @(posedge clock); #1;
    chk("wr_en", wr_en, m_en);
    if (m_en) begin
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, m_data);
    end
    chk("busy_vec", busy_vec, m_busy);
    chk("stall_req", stall_req, m_stall);
  endtask

  task automatic drv(input bit pv, input logic [4:0] prd,
                     input logic [31:0] pd,
                     input bit iss, input logic [4:0] ird,
                     input bit mv, input logic [4:0] mrd,
                     input logic [31:0] md);
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    md_issue = iss; md_issue_rd = ird;
    md_valid = mv; md_rd = mrd; md_data = md;
    step();
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    pipe_valid = 0; md_issue = 0; md_valid = 0;
    reset = 1'b1; #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_ready", md_ready, 1);
    q.delete();
    m_busy = '0; m_wait = 0; m_stall = 0; m_en = 0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2;
    apply_reset();

    // Pipeline write, then idle.
    drv(1, 5, 32'h1234, 0, 0, 0, 0, 0);
    chk("t1_addr", wr_addr, 5);
    chk("t1_data", wr_data, 32'h1234);
    idle();
    chk("t1_idle_en", wr_en, 0);

    // Scoreboard set and clear through the queue.
    drv(0, 0, 0, 1, 9, 0, 0, 0);
    chk("t2_busy_set", busy_vec[9], 1);
    drv(0, 0, 0, 0, 0, 1, 9, 32'hDEAD);
    idle();
    chk("t2_addr", wr_addr, 9);
    chk("t2_busy_clr", busy_vec[9], 0);

    // Collision: pipeline first, mul/div next.
    drv(1, 4, 32'hB, 0, 0, 1, 3, 32'hA);
    chk("t3_first", wr_addr, 4);
    idle();
    chk("t3_second", wr_addr, 3);
    chk("t3_sec_data", wr_data, 32'hA);
    idle();

    // Fill the queue under pipeline pressure until starvation.
    drv(0, 0, 0, 1, 6, 0, 0, 0);
    drv(0, 0, 0, 1, 7, 0, 0, 0);
    drv(1, 10, 32'h100, 0, 0, 1, 6, 32'h66);
    drv(1, 11, 32'h101, 0, 0, 1, 7, 32'h77);
    chk("t4_full", md_ready, 0);
    for (int i = 0; i < 5; i++)
      drv(1, 12, 32'h200 + i, 0, 0, 1, 8, 32'h88);
    chk("t4_stall", stall_req, 1);
    idle();
    chk("t4_drain0", wr_addr, 6);
    chk("t4_unstall", stall_req, 0);
    idle();
    chk("t4_drain1", wr_addr, 7);
    idle();

    // Register zero is consumed silently.
    drv(1, 0, 32'hFFFF, 0, 0, 1, 0, 32'h55);
    chk("t5_pipe0", wr_en, 0);
    idle();
    chk("t5_md0", wr_en, 0);
    idle();

`ifdef WB_BYPASS_EN
    rs_a = 5; rs_b = 3;
    drv(1, 5, 32'h5555, 0, 0, 0, 0, 0);
    chk("fwd_a_hit", fwd_a_hit, 1);
    chk("fwd_a_data", fwd_a_data, 32'h5555);
    chk("fwd_b_hit", fwd_b_hit, 0);
    idle();
    chk("fwd_a_idle", fwd_a_hit, 0);
`endif

    // Reset with two queued results outstanding.
    drv(0, 0, 0, 1, 9, 0, 0, 0);
    drv(0, 0, 0, 1, 10, 0, 0, 0);
    drv(1, 11, 32'h11, 0, 0, 1, 9, 32'h99);
    drv(1, 12, 32'h12, 0, 0, 1, 10, 32'hAA);
    chk("t6_busy", busy_vec, 32'h0000_0600);
    apply_reset();
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) apply_reset();
      drv(m_stall ? 1'b0 : 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)),
          1'($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 31)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
